axis_broadcast: RTL and testbench
=================================

# axis_broadcast

Parametrised AXI-Stream broadcaster: one slave stream fans out to N_PORTS master streams with a lossless fork handshake. Each beat is held until every port enabled at acceptance has taken it, so slow consumers stall the source and nothing is duplicated or lost. A per-port runtime enable mask removes unused consumers without rebuilding. The block sits between ADC/DDS stream sources and the parallel demod/logging/DMA paths of the dissemination datapath.

## Interface
- AXIS_TDATA_WIDTH, 32: tdata width in bits.
- N_PORTS, 4: number of master ports, legal 1..8 (MAX_PORTS).
- STALL_LIMIT, 1024: stall cycles before a forced release; used only with AXIS_BROADCAST_DROP_EN; must be ≥ 2.

- clk  in  1  stream clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset; deassertion synchronised externally.
- s_axis_data_tdata  in  AXIS_TDATA_WIDTH  input beat.
- s_axis_data_tvalid  in  1  input valid.
- s_axis_data_tready  out  1  input ready.
- port_en  in  N_PORTS  per-port enable, sampled only on input acceptance.
- m_axis_tdata  out  N_PORTS*AXIS_TDATA_WIDTH  port i occupies bits [i*W +: W].
- m_axis_tvalid  out  N_PORTS  per-port valid.
- m_axis_tready  in  N_PORTS  per-port ready.
- drop_count  out  16  saturating count of forced releases; port exists only with AXIS_BROADCAST_DROP_EN.

## Operation
- State: data_q (W bits), pending_q (N_PORTS bits). Block is EMPTY when pending_q == 0, HOLD otherwise.
- m_axis_tvalid = pending_q. Every m_axis_tdata slice = data_q.
- done = pending_q & m_axis_tvalid & m_axis_tready.
- s_axis_data_tready = ((pending_q & ~done) == 0) while rst is high. Ready is combinational from m_axis_tready, with no registered ready path.
- On accept (s_tvalid & s_tready):
  - data_q <= s_tdata.
  - pending_q <= port_en.
- Otherwise pending_q <= pending_q & ~done. data_q holds.
- port_en == 0 at accept: the beat is consumed and discarded, and pending_q stays 0.
- port_en changes while in HOLD do not affect the in-flight beat.
- A port with pending_q[i] == 0 ignores its tready.
- Once asserted, m_axis_tvalid[i] holds with stable data until that port handshakes (AXIS rule).
- Reset mid-beat: the pending beat is discarded and no output handshake completes.

## Timing
- Reset values:
  - data_q = 0.
  - pending_q = 0.
  - all m_axis_tvalid = 0.
  - s_axis_data_tready = 0 while rst is low, and 1 in the first cycle after release.
  - drop_count = 0.
- Latency: a beat accepted at edge k is valid on the enabled ports after edge k, one cycle.
- Throughput is 1 beat/cycle when all enabled ports hold tready high.
- Simultaneous final-port handshake and new input accept are allowed in the same cycle.
- Ports complete independently. A port that handshook stays invalid until the next accept, even while others stall.

## Configuration
- AXIS_BROADCAST_DROP_EN defined:
  - A stall counter increments each cycle with pending_q != 0 and no accept. It clears on accept and on reaching the limit.
  - When the counter equals STALL_LIMIT-1, pending_q is cleared on the next edge, forcing release of the ports still pending.
  - That event increments drop_count once, saturating at 0xFFFF.
  - One wedged consumer therefore cannot hang the source indefinitely.
- Macro undefined:
  - No counter and no drop_count port.
  - The stall is unbounded, giving strictly lossless behaviour.

## Structure
- Shared package axis_broadcast_pkg:
  - MAX_PORTS = 8.
  - DROP_CNT_W = 16.
  - The function for port slice index.
- Sub-module axis_broadcast_stall_timer is instantiated only under the macro. Inputs: clk, rst, stalled, accept. Outputs: force_release, drop_count.
- Target 150–250 lines total.

## Test plan
- N_PORTS=4, port_en=4'hF, all tready=1, stream 0x1..0x100 back-to-back:
  - Every port receives 256 beats in order.
  - s_tready stays 1 throughout.
- Port 2 holds tready=0 for 10 cycles after accepting 0xA5:
  - Ports 0, 1 and 3 take 0xA5 once each and then deassert valid.
  - s_tready = 0 for those 10 cycles.
  - Port 2 then takes 0xA5, and in that same cycle the next beat is accepted.
- port_en=4'b0101 at accept of 0x33, switched to 4'hF during HOLD:
  - Only ports 0 and 2 see 0x33.
  - The next beat goes to all four ports.
- port_en=0, send 0x77:
  - s_tready stays 1.
  - No m_tvalid asserts.
  - The beat is discarded.
- Assert rst low while pending_q=4'b1000:
  - All m_tvalid drop asynchronously.
  - s_tready = 0.
  - After release there are no stale beats and s_tready = 1.
- With AXIS_BROADCAST_DROP_EN and STALL_LIMIT=16, port 1 never ready:
  - Release occurs 16 cycles after the accept.
  - drop_count increments to 1, then 2 on the next beat.
  - Other ports are unaffected.

Source files
------------

// File: rtl/axis_broadcast_pkg.sv
// ============================================================================
// Module      : axis_broadcast_pkg
// Description : Shared constants and helpers for the AXI-Stream broadcaster.
//               MAX_PORTS   - largest legal N_PORTS
//               DROP_CNT_W  - width of the forced-release counter
//               port_lsb()  - bit offset of a port's tdata slice
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_broadcast_pkg;

  localparam int MAX_PORTS  = 8;
  localparam int DROP_CNT_W = 16;

  // Lowest bit index of port 'port' inside the flattened m_axis_tdata bus.
  function automatic int unsigned port_lsb(input int unsigned port,
                                           input int unsigned width);
    return port * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_broadcast_stall_timer.sv
// ============================================================================
// Module      : axis_broadcast_stall_timer
// Description : Watchdog for the broadcaster. Counts cycles in which a beat is
//               held with no new acceptance; after STALL_LIMIT such cycles it
//               forces release of the held beat and bumps a saturating
//               drop counter. Only built with AXIS_BROADCAST_DROP_EN.
// Ports       : clk           in   stream clock
//               rst           in   asynchronous active-low reset
//               stalled       in   beat held and no accept this cycle
//               accept        in   input handshake this cycle
//               force_release out  clear all pending ports on next edge
//               drop_count    out  saturating count of forced releases
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_broadcast_stall_timer
  import axis_broadcast_pkg::*;
#(
  parameter int STALL_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stalled,
  input  logic                  accept,
  output logic                  force_release,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int c_CNT_W = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [c_CNT_W-1:0] c_LIMIT_M1 = c_CNT_W'(STALL_LIMIT - 1);

  logic [c_CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q,  drop_cnt_d;

  // The counter value c means c stalled edges have elapsed since accept, so
  // the release lands on the STALL_LIMIT-th edge after the accept.
  assign force_release = stalled && (stall_cnt_q == c_LIMIT_M1);
  assign drop_count    = drop_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (accept || force_release) begin
      stall_cnt_d = '0;
    end else if (stalled) begin
      stall_cnt_d = stall_cnt_q + c_CNT_W'(1);
    end
    if (force_release && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_broadcast.sv
// ============================================================================
// Module      : axis_broadcast
// Description : Lossless AXI-Stream 1:N broadcaster. An accepted beat is held
//               until every port enabled at acceptance has handshaken it;
//               ports complete independently. Optional feature macro
//               AXIS_BROADCAST_DROP_EN adds a stall watchdog that force-
//               releases a wedged beat and exposes drop_count.
// Ports       : clk                in   stream clock
//               rst                in   asynchronous active-low reset
//               s_axis_data_tdata  in   input beat
//               s_axis_data_tvalid in   input valid
//               s_axis_data_tready out  input ready (combinational)
//               port_en            in   per-port enable, sampled on accept
//               m_axis_tdata       out  port i at bits [i*W +: W]
//               m_axis_tvalid      out  per-port valid
//               m_axis_tready      in   per-port ready
//               drop_count         out  forced releases (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_broadcast
  import axis_broadcast_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int N_PORTS          = 4,
  parameter int STALL_LIMIT      = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_data_tdata,
  input  logic                          s_axis_data_tvalid,
  output logic                          s_axis_data_tready,
  input  logic [N_PORTS-1:0]            port_en,
  output logic [N_PORTS*AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [N_PORTS-1:0]            m_axis_tvalid,
  input  logic [N_PORTS-1:0]            m_axis_tready
`ifdef AXIS_BROADCAST_DROP_EN
  ,
  output logic [DROP_CNT_W-1:0]         drop_count
`endif
);

  if ((N_PORTS < 1) || (N_PORTS > MAX_PORTS)) begin : g_bad_ports
    $error("axis_broadcast: N_PORTS out of range");
  end

  logic [AXIS_TDATA_WIDTH-1:0] data_q, data_d;
  logic [N_PORTS-1:0]          pending_q, pending_d;
  logic [N_PORTS-1:0]          done;
  logic                        accept;
  logic                        s_ready;

  // tvalid mirrors pending_q, so a port's handshake only needs its tready.
  assign done    = pending_q & m_axis_tready;
  // Ready as soon as the last outstanding port handshakes this cycle, which
  // allows back-to-back beats; forced low while reset is asserted.
  assign s_ready = rst & ((pending_q & ~done) == '0);
  assign accept  = s_axis_data_tvalid & s_ready;

  assign s_axis_data_tready = s_ready;
  assign m_axis_tvalid      = pending_q;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign m_axis_tdata[port_lsb(gi, AXIS_TDATA_WIDTH) +: AXIS_TDATA_WIDTH] = data_q;
  end

`ifdef AXIS_BROADCAST_DROP_EN
  logic force_release;
  logic stalled;

  assign stalled = (pending_q != '0) & ~accept;

  axis_broadcast_stall_timer #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_timer (
    .clk           (clk),
    .rst           (rst),
    .stalled       (stalled),
    .accept        (accept),
    .force_release (force_release),
    .drop_count    (drop_count)
  );
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = ^STALL_LIMIT;
`endif

  always_comb begin
    data_d    = data_q;
    pending_d = pending_q & ~done;
    if (accept) begin
      // port_en == 0 leaves pending_d at zero: the beat is silently consumed.
      data_d    = s_axis_data_tdata;
      pending_d = port_en;
    end
`ifdef AXIS_BROADCAST_DROP_EN
    else if (force_release) begin
      pending_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_broadcast.sv
// ============================================================================
// Module      : tb_axis_broadcast
// Description : Directed self-checking bench for axis_broadcast (4 ports,
//               32-bit data, STALL_LIMIT 16). Drop-counter scenario is built
//               only with AXIS_BROADCAST_DROP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_broadcast;

  localparam int W  = 32;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [NP-1:0] port_en;
  logic [NP*W-1:0] m_tdata;
  logic [NP-1:0] m_tvalid;
  logic [NP-1:0] m_tready;
`ifdef AXIS_BROADCAST_DROP_EN
  logic [15:0]   drop_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_broadcast #(
    .AXIS_TDATA_WIDTH (W),
    .N_PORTS          (NP),
    .STALL_LIMIT      (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .port_en            (port_en),
    .m_axis_tdata       (m_tdata),
    .m_axis_tvalid      (m_tvalid),
    .m_axis_tready      (m_tready)
`ifdef AXIS_BROADCAST_DROP_EN
    ,
    .drop_count         (drop_count)
`endif
  );

  function automatic logic [W-1:0] slice(input int p);
    return m_tdata[p*W +: W];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) step();
    n_cmp++; if (m_tvalid !== 4'b0000) begin n_err++; $display("FAIL reset_tvalid: got %b want 0000", m_tvalid); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    n_cmp++; if (m_tdata !== '0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
`ifdef AXIS_BROADCAST_DROP_EN
    n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
`endif
    rst = 1'b1;
    #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL release_tready: got %b want 1", s_tready); end
  endtask

  task automatic test_back_to_back;
    port_en  = 4'hF;
    m_tready = 4'hF;
    s_tvalid = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      s_tdata = W'(i);
      #1;
      n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL b2b_tready beat %0d: got %b want 1", i, s_tready); end
      step();
      n_cmp++; if (m_tvalid !== 4'hF) begin n_err++; $display("FAIL b2b_tvalid beat %0d: got %b want 1111", i, m_tvalid); end
      for (int p = 0; p < NP; p++) begin
        n_cmp++; if (slice(p) !== W'(i)) begin n_err++; $display("FAIL b2b_data port %0d: got %h want %h", p, slice(p), i); end
      end
    end
    s_tvalid = 1'b0;
    step();
    n_cmp++; if (m_tvalid !== 4'h0) begin n_err++; $display("FAIL b2b_drain: got %b want 0000", m_tvalid); end
  endtask

  task automatic test_stall;
    port_en  = 4'hF;
    m_tready = 4'b1011;
    s_tdata  = 32'hA5;
    s_tvalid = 1'b1;
    #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL stall_pre_tready: got %b want 1", s_tready); end
    step();
    s_tdata = 32'hB6;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (m_tvalid !== ((c == 0) ? 4'hF : 4'b0100)) begin n_err++; $display("FAIL stall_tvalid cyc %0d: got %b", c, m_tvalid); end
      n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL stall_tready cyc %0d: got %b want 0", c, s_tready); end
      n_cmp++; if (slice(2) !== 32'hA5) begin n_err++; $display("FAIL stall_data cyc %0d: got %h want a5", c, slice(2)); end
      step();
    end
    m_tready = 4'hF;
    #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL stall_release_tready: got %b want 1", s_tready); end
    n_cmp++; if (m_tvalid !== 4'b0100) begin n_err++; $display("FAIL stall_release_tvalid: got %b want 0100", m_tvalid); end
    step();
    n_cmp++; if (m_tvalid !== 4'hF) begin n_err++; $display("FAIL stall_next_tvalid: got %b want 1111", m_tvalid); end
    n_cmp++; if (slice(0) !== 32'hB6 || slice(3) !== 32'hB6) begin n_err++; $display("FAIL stall_next_data: got %h want b6", m_tdata); end
    s_tvalid = 1'b0;
    step();
    n_cmp++; if (m_tvalid !== 4'h0) begin n_err++; $display("FAIL stall_drain: got %b want 0000", m_tvalid); end
  endtask

  task automatic test_port_en_change;
    port_en  = 4'b0101;
    m_tready = 4'h0;
    s_tdata  = 32'h33;
    s_tvalid = 1'b1;
    step();
    port_en = 4'hF;
    s_tdata = 32'h44;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (m_tvalid !== 4'b0101) begin n_err++; $display("FAIL en_tvalid cyc %0d: got %b want 0101", c, m_tvalid); end
      n_cmp++; if (slice(0) !== 32'h33 || slice(2) !== 32'h33) begin n_err++; $display("FAIL en_data cyc %0d: got %h want 33", c, m_tdata); end
      n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL en_tready cyc %0d: got %b want 0", c, s_tready); end
      step();
    end
    m_tready = 4'hF;
    #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL en_release_tready: got %b want 1", s_tready); end
    step();
    n_cmp++; if (m_tvalid !== 4'hF) begin n_err++; $display("FAIL en_next_tvalid: got %b want 1111", m_tvalid); end
    n_cmp++; if (slice(1) !== 32'h44 || slice(3) !== 32'h44) begin n_err++; $display("FAIL en_next_data: got %h want 44", m_tdata); end
    s_tvalid = 1'b0;
    step();
    n_cmp++; if (m_tvalid !== 4'h0) begin n_err++; $display("FAIL en_drain: got %b want 0000", m_tvalid); end
  endtask

  task automatic test_discard;
    port_en  = 4'h0;
    m_tready = 4'hF;
    s_tdata  = 32'h77;
    s_tvalid = 1'b1;
    #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL discard_tready: got %b want 1", s_tready); end
    step();
    s_tvalid = 1'b0;
    #1;
    n_cmp++; if (m_tvalid !== 4'h0) begin n_err++; $display("FAIL discard_tvalid: got %b want 0000", m_tvalid); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL discard_tready_after: got %b want 1", s_tready); end
    port_en  = 4'hF;
    s_tdata  = 32'h88;
    s_tvalid = 1'b1;
    step();
    n_cmp++; if (m_tvalid !== 4'hF || slice(1) !== 32'h88) begin n_err++; $display("FAIL discard_next: got %b/%h want 1111/88", m_tvalid, slice(1)); end
    s_tvalid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_beat;
    port_en  = 4'hF;
    m_tready = 4'b0111;
    s_tdata  = 32'hC3;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    step();
    n_cmp++; if (m_tvalid !== 4'b1000) begin n_err++; $display("FAIL rmid_pending: got %b want 1000", m_tvalid); end
    rst = 1'b0;
    #1;
    n_cmp++; if (m_tvalid !== 4'h0) begin n_err++; $display("FAIL rmid_async_tvalid: got %b want 0000", m_tvalid); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rmid_tready: got %b want 0", s_tready); end
    m_tready = 4'hF;
    step();
    rst = 1'b1;
    #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL rmid_release_tready: got %b want 1", s_tready); end
    step();
    n_cmp++; if (m_tvalid !== 4'h0) begin n_err++; $display("FAIL rmid_stale: got %b want 0000", m_tvalid); end
    n_cmp++; if (slice(3) !== 32'h0) begin n_err++; $display("FAIL rmid_data: got %h want 0", slice(3)); end
  endtask

`ifdef AXIS_BROADCAST_DROP_EN
  task automatic test_drop;
    port_en  = 4'hF;
    m_tready = 4'b1101;
    for (int b = 1; b <= 2; b++) begin
      s_tdata  = (b == 1) ? 32'hD1 : 32'hD2;
      s_tvalid = 1'b1;
      if (b == 1) step();
      s_tvalid = 1'b0;
      n_cmp++; if (m_tvalid !== 4'hF || slice(0) !== s_tdata) begin n_err++; $display("FAIL drop_accept beat %0d: got %b/%h", b, m_tvalid, slice(0)); end
      for (int c = 1; c <= 15; c++) begin
        step();
        n_cmp++; if (m_tvalid !== 4'b0010) begin n_err++; $display("FAIL drop_hold beat %0d cyc %0d: got %b want 0010", b, c, m_tvalid); end
        n_cmp++; if (drop_count !== 16'(b - 1)) begin n_err++; $display("FAIL drop_count_hold beat %0d: got %0d want %0d", b, drop_count, b - 1); end
      end
      s_tdata  = 32'hD2;
      s_tvalid = (b == 1);
      step();
      n_cmp++; if (m_tvalid !== 4'h0) begin n_err++; $display("FAIL drop_release beat %0d: got %b want 0000", b, m_tvalid); end
      n_cmp++; if (drop_count !== 16'(b)) begin n_err++; $display("FAIL drop_count beat %0d: got %0d want %0d", b, drop_count, b); end
      if (b == 1) step();
    end
    s_tvalid = 1'b0;
  endtask
`endif

  initial begin
    rst      = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    port_en  = '0;
    m_tready = '0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_port_en_change();
    test_discard();
    test_reset_mid_beat();
`ifdef AXIS_BROADCAST_DROP_EN
    test_drop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
